rgb2ycbcr: RTL and testbench

Pipelined colour-space converter that sits directly downstream of the RAW-to-RGB demosaic stage. It consumes its 24-bit RGB pixel stream through a valid/ready handshake, along with the start, line-last and last sideband flags. It emits full-range BT.601 YCbCr with the same handshake and the flags kept aligned to their pixels. A line-length monitor flags malformed lines coming from the upstream crop.

---
 rtl/isp_pkg.sv | 38 +++
 rtl/sat_u8.sv | 20 ++
 rtl/rgb2ycbcr.sv | 177 +++++++++++++++++
 tb/tb_rgb2ycbcr.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared ISP definitions: pixel widths, BT.601 full-range coefficients and a few
// helpers used by the colour-space converter.
package isp_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PIX_W  = 24;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned SUM_W  = 18;
  localparam int unsigned CNT_W  = 11;

  // Coefficients scaled by 256.
  localparam logic [DATA_W-1:0] KY_R  = 8'd77;
  localparam logic [DATA_W-1:0] KY_G  = 8'd150;
  localparam logic [DATA_W-1:0] KY_B  = 8'd29;
  localparam logic [DATA_W-1:0] KCB_R = 8'd43;
  localparam logic [DATA_W-1:0] KCB_G = 8'd85;
  localparam logic [DATA_W-1:0] KCR_G = 8'd107;
  localparam logic [DATA_W-1:0] KCR_B = 8'd21;
  // Doubles as the 0.5 coefficient on the dominant chroma term and the Y rounding term.
  localparam logic [DATA_W-1:0] K_HALF = 8'd128;
  // 128 * 256 chroma offset plus 128 rounding.
  localparam logic signed [SUM_W-1:0] K_CHROMA_OFF = 18'sd32896;

  typedef struct packed {
    logic start;
    logic line_last;
    logic last;
  } flags_t;

  function automatic logic [PROD_W-1:0] mul8(logic [DATA_W-1:0] a, logic [DATA_W-1:0] k);
    return {8'd0, a} * {8'd0, k};
  endfunction

  function automatic logic signed [SUM_W-1:0] ext18(logic [PROD_W-1:0] p);
    return signed'({2'b00, p});
  endfunction

endpackage

// File: rtl/sat_u8.sv
// Combinational clamp of a signed 18-bit value to unsigned 8 bits.
//   val_i : signed input (already scaled)
//   sat_o : 0 for negative inputs, 255 for inputs above 255, else the low byte
module sat_u8
  import isp_pkg::*;
(
  input  logic signed [SUM_W-1:0]  val_i,
  output logic        [DATA_W-1:0] sat_o
);

  always_comb begin
    sat_o = val_i[DATA_W-1:0];
    if (val_i[SUM_W-1]) begin
      sat_o = '0;
    end else if (|val_i[SUM_W-2:DATA_W]) begin
      sat_o = '1;
    end
  end

endmodule

// File: rtl/rgb2ycbcr.sv
// Three-stage RGB -> full-range BT.601 YCbCr converter with valid/ready handshake,
// aligned frame sideband flags and a sticky line-length monitor.
//   clk, rst_n        : clock, asynchronous active-low reset
//   frame_width       : expected pixels per line
//   src_*             : input pixel stream {R,G,B} with start/line_last/last flags
//   dst_*             : output pixel stream {Y,Cb,Cr} with aligned flags
//   err_line          : sticky, set on a line whose length differs from frame_width
module rgb2ycbcr
  import isp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] frame_width,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [PIX_W-1:0] src_data,
  input  logic             src_start,
  input  logic             src_line_last,
  input  logic             src_last,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [PIX_W-1:0] dst_data,
  output logic             dst_start,
  output logic             dst_line_last,
  output logic             dst_last,
  output logic             err_line
);

  logic ce;
  logic accept;

  // Whole pipeline stalls together; bubbles are kept.
  assign ce        = dst_ready | ~dst_valid;
  assign src_ready = ce;
  assign accept    = src_valid & ce;

  logic [DATA_W-1:0] r, g, b;
  assign r = src_data[23:16];
  assign g = src_data[15:8];
  assign b = src_data[7:0];

  // Stage 1: products
  logic                v1_q;
  flags_t              f1_q;
  logic [PROD_W-1:0]   p_yr_q, p_yg_q, p_yb_q;
  logic [PROD_W-1:0]   p_cbr_q, p_cbg_q, p_cbb_q;
  logic [PROD_W-1:0]   p_crr_q, p_crg_q, p_crb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      f1_q    <= '0;
      p_yr_q  <= '0;
      p_yg_q  <= '0;
      p_yb_q  <= '0;
      p_cbr_q <= '0;
      p_cbg_q <= '0;
      p_cbb_q <= '0;
      p_crr_q <= '0;
      p_crg_q <= '0;
      p_crb_q <= '0;
    end else if (ce) begin
      v1_q    <= accept;
      // Flags are zeroed on bubbles so later stages never carry stale flags.
      f1_q    <= '{start: src_start & accept, line_last: src_line_last & accept,
                   last: src_last & accept};
      p_yr_q  <= mul8(r, KY_R);
      p_yg_q  <= mul8(g, KY_G);
      p_yb_q  <= mul8(b, KY_B);
      p_cbr_q <= mul8(r, KCB_R);
      p_cbg_q <= mul8(g, KCB_G);
      p_cbb_q <= mul8(b, K_HALF);
      p_crr_q <= mul8(r, K_HALF);
      p_crg_q <= mul8(g, KCR_G);
      p_crb_q <= mul8(b, KCR_B);
    end
  end

  // Stage 2: signed sums with rounding / chroma offset
  logic                    v2_q;
  flags_t                  f2_q;
  logic signed [SUM_W-1:0] ys_q, cbs_q, crs_q;
  logic signed [SUM_W-1:0] ys_d, cbs_d, crs_d;

  always_comb begin
    ys_d  = ext18(p_yr_q) + ext18(p_yg_q) + ext18(p_yb_q) + ext18({8'd0, K_HALF});
    cbs_d = ext18(p_cbb_q) - ext18(p_cbr_q) - ext18(p_cbg_q) + K_CHROMA_OFF;
    crs_d = ext18(p_crr_q) - ext18(p_crg_q) - ext18(p_crb_q) + K_CHROMA_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      f2_q  <= '0;
      ys_q  <= '0;
      cbs_q <= '0;
      crs_q <= '0;
    end else if (ce) begin
      v2_q  <= v1_q;
      f2_q  <= f1_q;
      ys_q  <= ys_d;
      cbs_q <= cbs_d;
      crs_q <= crs_d;
    end
  end

  // Stage 3: scale by 1/256 and clamp
  logic signed [SUM_W-1:0] ys_sh, cbs_sh, crs_sh;
  logic [DATA_W-1:0]       y_sat, cb_sat, cr_sat;

  assign ys_sh  = ys_q >>> 8;
  assign cbs_sh = cbs_q >>> 8;
  assign crs_sh = crs_q >>> 8;

  sat_u8 u_sat_y  (.val_i(ys_sh),  .sat_o(y_sat));
  sat_u8 u_sat_cb (.val_i(cbs_sh), .sat_o(cb_sat));
  sat_u8 u_sat_cr (.val_i(crs_sh), .sat_o(cr_sat));

  logic             dst_valid_q;
  flags_t           f3_q;
  logic [PIX_W-1:0] dst_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_valid_q <= 1'b0;
      f3_q        <= '0;
      dst_data_q  <= '0;
    end else if (ce) begin
      dst_valid_q <= v2_q;
      f3_q        <= f2_q;
      dst_data_q  <= {y_sat, cb_sat, cr_sat};
    end
  end

  assign dst_valid     = dst_valid_q;
  assign dst_data      = dst_data_q;
  assign dst_start     = f3_q.start;
  assign dst_line_last = f3_q.line_last;
  assign dst_last      = f3_q.last;

  // Line-length monitor on accepted input beats
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] beat_cnt;
  logic             err_q, err_d;

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    err_d     = err_q;
    // Position of this beat within its line, 1-based; a start beat opens a new line.
    beat_cnt  = src_start ? 11'd1 : pix_cnt_q + 11'd1;
    if (accept) begin
      pix_cnt_d = beat_cnt;
      if (src_start) begin
        err_d = 1'b0;
      end
      if (src_line_last) begin
        pix_cnt_d = '0;
        if (beat_cnt != frame_width) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_line = err_q;

endmodule

// File: tb/tb_rgb2ycbcr.sv
module tb_rgb2ycbcr;

  logic        clk;
  logic        rst_n;
  logic [10:0] frame_width;
  logic        src_valid;
  logic        src_ready;
  logic [23:0] src_data;
  logic        src_start;
  logic        src_line_last;
  logic        src_last;
  logic        dst_valid;
  logic        dst_ready;
  logic [23:0] dst_data;
  logic        dst_start;
  logic        dst_line_last;
  logic        dst_last;
  logic        err_line;

  int n_checks = 0;
  int n_fail   = 0;
  logic [26:0] outq[$];

  rgb2ycbcr u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_width  (frame_width),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_data     (src_data),
    .src_start    (src_start),
    .src_line_last(src_line_last),
    .src_last     (src_last),
    .dst_valid    (dst_valid),
    .dst_ready    (dst_ready),
    .dst_data     (dst_data),
    .dst_start    (dst_start),
    .dst_line_last(dst_line_last),
    .dst_last     (dst_last),
    .err_line     (err_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Records a transfer that the coming edge will perform, then advances one clock.
  task automatic tick();
    if (dst_valid && dst_ready) begin
      outq.push_back({dst_start, dst_line_last, dst_last, dst_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d, input logic st, input logic ll, input logic ls);
    src_valid     = 1'b1;
    src_data      = d;
    src_start     = st;
    src_line_last = ll;
    src_last      = ls;
    dst_ready     = 1'b1;
    tick();
    src_valid     = 1'b0;
    src_start     = 1'b0;
    src_line_last = 1'b0;
    src_last      = 1'b0;
  endtask

  function automatic int clamp8(int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Reference: full-range BT.601 with /256 integer coefficients.
  function automatic logic [23:0] ycc(logic [23:0] rgb);
    int r, g, b, y, cb, cr;
    r  = int'(rgb[23:16]);
    g  = int'(rgb[15:8]);
    b  = int'(rgb[7:0]);
    y  = clamp8((77 * r + 150 * g + 29 * b + 128) / 256);
    cb = clamp8((128 * b - 43 * r - 85 * g + 32896) / 256);
    cr = clamp8((128 * r - 107 * g - 21 * b + 32896) / 256);
    return {y[7:0], cb[7:0], cr[7:0]};
  endfunction

  function automatic logic [23:0] pix(int i);
    logic [7:0] r, g, b;
    r = 8'(i * 37 + 5);
    g = 8'(i * 91);
    b = 8'(255 - i * 13);
    return {r, g, b};
  endfunction

  initial begin
    logic [23:0] prim_in  [4];
    logic [23:0] prim_exp [4];
    logic [23:0] frozen;
    int sent, c, stall_n;

    prim_in[0]  = 24'hFFFFFF; prim_exp[0] = 24'hFF8080;
    prim_in[1]  = 24'h000000; prim_exp[1] = 24'h008080;
    prim_in[2]  = 24'hFF0000; prim_exp[2] = 24'h4D55FF;
    prim_in[3]  = 24'h0000FF; prim_exp[3] = 24'h1DFF6B;

    rst_n         = 1'b0;
    frame_width   = 11'd2047;
    src_valid     = 1'b0;
    src_data      = '0;
    src_start     = 1'b0;
    src_line_last = 1'b0;
    src_last      = 1'b0;
    dst_ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // Reset state
    check_eq("rst_valid", 32'(dst_valid), 32'd0);
    check_eq("rst_data", 32'(dst_data), 32'd0);
    check_eq("rst_flags", 32'({dst_start, dst_line_last, dst_last}), 32'd0);
    check_eq("rst_err", 32'(err_line), 32'd0);
    check_eq("rst_ready", 32'(src_ready), 32'd1);

    // Primary colours back-to-back, latency of three edges
    outq.delete();
    for (int i = 0; i < 4; i++) begin
      src_valid = 1'b1;
      src_data  = prim_in[i];
      tick();
      if (i == 0) check_eq("lat_edge1", 32'(dst_valid), 32'd0);
      if (i == 1) check_eq("lat_edge2", 32'(dst_valid), 32'd0);
      if (i == 2) begin
        check_eq("lat_edge3", 32'(dst_valid), 32'd1);
        check_eq("lat_data", 32'(dst_data), 32'hFF8080);
      end
    end
    src_valid = 1'b0;
    repeat (4) tick();
    check_eq("prim_count", 32'(outq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < outq.size()) check_eq("prim_data", 32'(outq[i][23:0]), 32'(prim_exp[i]));
    end

    // Backpressure: 5-cycle stall mid-stream with src_valid held high
    outq.delete();
    sent    = 0;
    c       = 0;
    stall_n = 0;
    frozen  = '0;
    while (outq.size() < 16 && c < 200) begin
      dst_ready = !(c >= 6 && c < 11);
      src_valid = (sent < 16);
      src_data  = pix(sent);
      #1;
      if (!dst_ready && dst_valid) begin
        if (stall_n == 0) begin
          check_eq("bp_ready_drop", 32'(src_ready), 32'd0);
          frozen = dst_data;
        end else begin
          check_eq("bp_freeze", 32'(dst_data), 32'(frozen));
        end
        stall_n++;
      end
      if (src_valid && src_ready) sent++;
      tick();
      c++;
    end
    src_valid = 1'b0;
    dst_ready = 1'b1;
    repeat (4) tick();
    check_eq("bp_stalls", 32'(stall_n), 32'd5);
    check_eq("bp_count", 32'(outq.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < outq.size()) check_eq("bp_data", 32'(outq[i][23:0]), 32'(ycc(pix(i))));
    end

    // Sideband alignment with random backpressure
    frame_width = 11'd4;
    outq.delete();
    sent = 0;
    c    = 0;
    while (outq.size() < 8 && c < 300) begin
      dst_ready     = 1'($urandom_range(0, 1));
      src_valid     = (sent < 8);
      src_data      = pix(sent + 20);
      src_start     = (sent == 0);
      src_line_last = (sent == 3) || (sent == 7);
      src_last      = (sent == 7);
      #1;
      if (src_valid && src_ready) sent++;
      tick();
      c++;
    end
    src_valid     = 1'b0;
    src_start     = 1'b0;
    src_line_last = 1'b0;
    src_last      = 1'b0;
    dst_ready     = 1'b1;
    repeat (4) tick();
    check_eq("sb_count", 32'(outq.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < outq.size()) begin
        check_eq("sb_flags", 32'(outq[k][26:24]),
                 32'({k == 0, (k == 3) || (k == 7), k == 7}));
        check_eq("sb_data", 32'(outq[k][23:0]), 32'(ycc(pix(k + 20))));
      end
    end
    check_eq("sb_no_err", 32'(err_line), 32'd0);

    // Line error: short line sets, good line holds, start clears
    send(24'h101010, 1'b1, 1'b0, 1'b0);
    send(24'h202020, 1'b0, 1'b0, 1'b0);
    check_eq("le_before", 32'(err_line), 32'd0);
    send(24'h303030, 1'b0, 1'b1, 1'b0);
    check_eq("le_set", 32'(err_line), 32'd1);
    for (int i = 0; i < 4; i++) send(24'h404040, 1'b0, (i == 3), 1'b0);
    check_eq("le_hold", 32'(err_line), 32'd1);
    send(24'h505050, 1'b1, 1'b0, 1'b0);
    check_eq("le_clear", 32'(err_line), 32'd0);
    for (int i = 0; i < 3; i++) send(24'h606060, 1'b0, (i == 2), (i == 2));
    check_eq("le_good_line", 32'(err_line), 32'd0);
    repeat (4) tick();

    // Bubbles: green on alternate cycles
    outq.delete();
    dst_ready = 1'b1;
    src_data  = 24'h00FF00;
    for (int j = 0; j < 16; j++) begin
      src_valid = (j < 12) && (j % 2 == 0);
      tick();
      if (j >= 2) check_eq("bub_valid", 32'(dst_valid), 32'((j % 2 == 0) && (j - 2 < 12)));
    end
    src_valid = 1'b0;
    check_eq("bub_count", 32'(outq.size()), 32'd6);
    foreach (outq[k]) check_eq("bub_data", 32'(outq[k][23:0]), 32'h952B15);

    // Reset with pixels in flight
    send(24'hFF0000, 1'b0, 1'b1, 1'b0);
    send(24'h00FF00, 1'b0, 1'b0, 1'b0);
    send(24'h0000FF, 1'b0, 1'b0, 1'b0);
    check_eq("mr_pre_valid", 32'(dst_valid), 32'd1);
    check_eq("mr_pre_err", 32'(err_line), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_valid", 32'(dst_valid), 32'd0);
    check_eq("mr_data", 32'(dst_data), 32'd0);
    check_eq("mr_err", 32'(err_line), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    outq.delete();
    repeat (6) tick();
    check_eq("mr_no_stale", 32'(outq.size()), 32'd0);
    check_eq("mr_idle_valid", 32'(dst_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
